// File: rtl/bcd_scan_display_pkg.sv
// Shared types and constants for the multiplexed BCD 7-segment display block.
package bcd_scan_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t DIGIT_ONES     = 2'd0;
    localparam digit_idx_t DIGIT_TENS     = 2'd1;
    localparam digit_idx_t DIGIT_HUNDREDS = 2'd2;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_ERR   = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [2:0] DEN_ONES     = 3'b001;
    localparam logic [2:0] DEN_TENS     = 3'b010;
    localparam logic [2:0] DEN_HUNDREDS = 3'b100;
    localparam logic [2:0] DEN_OFF      = 3'b000;

    function automatic logic [2:0] digit_onehot(input digit_idx_t d);
        logic [2:0] en;
        case (d)
            DIGIT_ONES:     en = DEN_ONES;
            DIGIT_TENS:     en = DEN_TENS;
            DIGIT_HUNDREDS: en = DEN_HUNDREDS;
            default:        en = DEN_OFF;
        endcase
        return en;
    endfunction

    function automatic logic [3:0] digit_nibble(input logic [11:0] word, input digit_idx_t d);
        logic [3:0] nib;
        case (d)
            DIGIT_ONES:     nib = word[3:0];
            DIGIT_TENS:     nib = word[7:4];
            DIGIT_HUNDREDS: nib = word[11:8];
            default:        nib = word[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// Data/strobe bundle between a BCD word producer and the scanned display driver.
interface bcd_scan_display_if;
    logic [11:0] bcd_in;
    logic        bcd_valid;
    logic [6:0]  seg;
    logic [2:0]  digit_en;
    logic        frame_done;

    modport master (
        output bcd_in, bcd_valid,
        input  seg, digit_en, frame_done
    );

    modport slave (
        input  bcd_in, bcd_valid,
        output seg, digit_en, frame_done
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to 7-segment decoder; non-BCD codes show 'E'.
module bcd_to_seg7
    import bcd_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Digit lookup with error glyph for 10-15
    always_comb begin
        o_seg = SEG_ERR;
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Latches a 3-digit BCD word and scans it onto a shared 7-segment bus.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_scan_display
    import bcd_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
) (
    input  logic               clk,
    input  logic               reset,
    bcd_scan_display_if.slave  bus
);

    localparam int             DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [11:0]      r_hold;
    logic [DIV_W-1:0] r_div;
    digit_idx_t       r_digit;
    logic [6:0]       r_seg;
    logic [2:0]       r_digit_en;
    logic             r_frame_done;

    logic             w_wrap;
    digit_idx_t       w_digit_next;
    logic [3:0]       w_nibble;
    logic [6:0]       w_dec_seg;
    logic [6:0]       w_seg_next;

    assign w_wrap   = (r_div == DIV_LAST);
    assign w_nibble = digit_nibble(r_hold, r_digit);

    bcd_to_seg7 u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    // Digit sequencer; an illegal code falls back to ONES immediately
    always_comb begin
        w_digit_next = DIGIT_ONES;
        case (r_digit)
            DIGIT_ONES:     w_digit_next = w_wrap ? DIGIT_TENS     : DIGIT_ONES;
            DIGIT_TENS:     w_digit_next = w_wrap ? DIGIT_HUNDREDS : DIGIT_TENS;
            DIGIT_HUNDREDS: w_digit_next = w_wrap ? DIGIT_ONES     : DIGIT_HUNDREDS;
            default:        w_digit_next = DIGIT_ONES;
        endcase
    end

    // Segment value for the active digit, optionally blanking leading zeros
    always_comb begin
        w_seg_next = w_dec_seg;
`ifdef BCD_SCAN_LZB_EN
        if ((r_digit == DIGIT_HUNDREDS) && (r_hold[11:8] == 4'd0)) begin
            w_seg_next = SEG_BLANK;
        end else if ((r_digit == DIGIT_TENS) && (r_hold[11:8] == 4'd0)
                     && (r_hold[7:4] == 4'd0)) begin
            w_seg_next = SEG_BLANK;
        end else begin
            w_seg_next = w_dec_seg;
        end
`else
        w_seg_next = w_dec_seg;
`endif
    end

    // Hold register, prescaler, digit state and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold       <= 12'h000;
            r_div        <= '0;
            r_digit      <= DIGIT_ONES;
            r_seg        <= SEG_BLANK;
            r_digit_en   <= DEN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            if (bus.bcd_valid) begin
                r_hold <= bus.bcd_in;
            end else begin
                r_hold <= r_hold;
            end
            r_div        <= w_wrap ? '0 : (r_div + DIV_W'(1));
            r_digit      <= w_digit_next;
            // Output stage sees the current hold/digit pair, so a capture and an
            // advance on the same edge land together one cycle later
            r_seg        <= w_seg_next;
            r_digit_en   <= digit_onehot(r_digit);
            r_frame_done <= w_wrap && (r_digit == DIGIT_HUNDREDS);
        end
    end

    assign bus.seg        = r_seg;
    assign bus.digit_en   = r_digit_en;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with REFRESH_DIV=4 (12-cycle frame).
module tb_bcd_scan_display;

    localparam int RD = 4;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    bcd_scan_display_if u_if ();

    bcd_scan_display #(.REFRESH_DIV(RD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] es, input logic [2:0] ee,
                       input logic ef);
        n_tests++;
        assert (u_if.seg === es) else begin
            n_fail++;
            $error("FAIL %s seg: got %h expected %h", tag, u_if.seg, es);
        end
        n_tests++;
        assert (u_if.digit_en === ee) else begin
            n_fail++;
            $error("FAIL %s digit_en: got %b expected %b", tag, u_if.digit_en, ee);
        end
        n_tests++;
        assert (u_if.frame_done === ef) else begin
            n_fail++;
            $error("FAIL %s frame_done: got %b expected %b", tag, u_if.frame_done, ef);
        end
    endtask

    // Step through frame positions first..last (1..12) checking each cycle
    task automatic scan(input string tag, input int first, input int last,
                        input logic [6:0] so, input logic [6:0] st, input logic [6:0] sh);
        logic [6:0] es;
        logic [2:0] ee;
        for (int k = first; k <= last; k++) begin
            step();
            if (k <= RD) begin
                es = so; ee = 3'b001;
            end else if (k <= 2 * RD) begin
                es = st; ee = 3'b010;
            end else begin
                es = sh; ee = 3'b100;
            end
            chk($sformatf("%s@%0d", tag, k), es, ee, (k == 3 * RD));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        u_if.bcd_in    = 12'h000;
        u_if.bcd_valid = 1'b0;

        // Reset state
        step(); step(); step();
        chk("reset", 7'h00, 3'b000, 1'b0);

        // Release with 127 captured on the first edge; seg still shows old hold=0
        reset = 1'b0;
        u_if.bcd_in    = 12'h127;
        u_if.bcd_valid = 1'b1;
        step();
        chk("first", 7'h3F, 3'b001, 1'b0);
        u_if.bcd_valid = 1'b0;
        scan("h127a", 2, 12, 7'h07, 7'h5B, 7'h06);
        scan("h127b", 1, 11, 7'h07, 7'h5B, 7'h06);
        u_if.bcd_in = 12'h0A5; u_if.bcd_valid = 1'b1;
        scan("h127b", 12, 12, 7'h07, 7'h5B, 7'h06);
        u_if.bcd_valid = 1'b0;

        // Invalid tens nibble shows E; zero hundreds blanks only with LZB
`ifdef BCD_SCAN_LZB_EN
        scan("h0A5", 1, 11, 7'h6D, 7'h79, 7'h00);
`else
        scan("h0A5", 1, 11, 7'h6D, 7'h79, 7'h3F);
`endif
        u_if.bcd_in = 12'h005; u_if.bcd_valid = 1'b1;
`ifdef BCD_SCAN_LZB_EN
        scan("h0A5", 12, 12, 7'h6D, 7'h79, 7'h00);
`else
        scan("h0A5", 12, 12, 7'h6D, 7'h79, 7'h3F);
`endif
        u_if.bcd_valid = 1'b0;

`ifdef BCD_SCAN_LZB_EN
        scan("h005", 1, 11, 7'h6D, 7'h00, 7'h00);
`else
        scan("h005", 1, 11, 7'h6D, 7'h3F, 7'h3F);
`endif
        u_if.bcd_in = 12'h111; u_if.bcd_valid = 1'b1;
`ifdef BCD_SCAN_LZB_EN
        scan("h005", 12, 12, 7'h6D, 7'h00, 7'h00);
`else
        scan("h005", 12, 12, 7'h6D, 7'h3F, 7'h3F);
`endif
        u_if.bcd_valid = 1'b0;

        // 999 captured on the ONES->TENS edge: tens appears directly as 6F
        scan("h111", 1, 3, 7'h06, 7'h06, 7'h06);
        u_if.bcd_in = 12'h999; u_if.bcd_valid = 1'b1;
        scan("h111", 4, 4, 7'h06, 7'h06, 7'h06);
        u_if.bcd_valid = 1'b0;
        scan("h999", 5, 12, 7'h6F, 7'h6F, 7'h6F);

        // Reset mid-hundreds, then a full fresh frame with hold cleared
        scan("h999b", 1, 10, 7'h6F, 7'h6F, 7'h6F);
        reset = 1'b1;
        step();
        chk("midrst", 7'h00, 3'b000, 1'b0);
        reset = 1'b0;
        step();
        chk("rerun@1", 7'h3F, 3'b001, 1'b0);
        scan("rerun", 2, 12, 7'h3F, 7'h3F, 7'h3F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
